// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - XGMII control codes and receive framer state type
package xgmii_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_FLUSH,
    RX_DROP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign w_do_rd   = rd_en && !empty;
  assign w_do_wr   = wr_en && (!full || w_do_rd);
  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign occupancy = r_count;
  assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xgmii_rx_framer.sv
// rtl/xgmii_rx_framer.sv - XGMII receive framer: strips start, realigns terminate, queues words
module xgmii_rx_framer #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   xgmii_rxd,
  input  logic [DATA_WIDTH/8-1:0] xgmii_rxc,
  output logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic [DATA_WIDTH/8-1:0] rx_keep,
  output logic                    rx_sop,
  output logic                    rx_eop,
  output logic                    rx_err,
  input  logic                    rx_ready,
  output logic [CNT_WIDTH-1:0]    rx_packet_count,
  output logic [CNT_WIDTH-1:0]    rx_drop_count,
  output logic                    rx_overflow
);
  import xgmii_pkg::*;

  localparam int LANES = DATA_WIDTH / 8;
  localparam int KW    = $clog2(LANES);
  localparam int EW    = DATA_WIDTH + LANES + 3;
  localparam int OW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OW-1:0] OCC_LAST = OW'(FIFO_DEPTH - 1);

  rx_state_t             r_state;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [LANES-1:0]      r_hold_keep;
  logic                  r_hold_valid;
  logic                  r_written;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic                  r_ovf;

  logic                  w_start;
  logic                  w_term_found;
  logic                  w_term0;
  logic [KW-1:0]         w_term_k;
  logic                  w_word_err;
  logic [LANES-1:0]      w_part_keep;
  logic [DATA_WIDTH-1:0] w_part_data;
  logic                  w_push_req;
  logic                  w_push_eop;
  logic                  w_push_err;
  logic [LANES-1:0]      w_push_keep;
  logic                  w_ovf;
  logic                  w_wr_en;
  logic [EW-1:0]         w_wr_data;
  logic                  w_good_eop;
  logic [EW-1:0]         w_rd_data;
  logic [OW-1:0]         w_occ;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;

  assign w_start = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
  assign w_term0 = w_term_found && (w_term_k == '0);

  // Descending scan so the lowest terminate lane wins; lanes below it are payload.
  always_comb begin
    w_term_found = 1'b0;
    w_term_k     = '0;
    w_word_err   = 1'b0;
    w_part_keep  = '0;
    w_part_data  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == XGMII_TERM)) begin
        w_term_found = 1'b1;
        w_term_k     = KW'(i);
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (!w_term_found || (KW'(i) < w_term_k)) begin
        w_part_keep[i]       = 1'b1;
        w_part_data[8*i +: 8] = xgmii_rxd[8*i +: 8];
        if (xgmii_rxc[i]) w_word_err = 1'b1;
      end
    end
  end

  always_comb begin
    w_push_req  = 1'b0;
    w_push_eop  = 1'b0;
    w_push_err  = 1'b0;
    w_push_keep = '1;
    case (r_state)
      RX_DATA: begin
        w_push_req = r_hold_valid && !w_start;
        w_push_eop = w_term0;
        w_push_err = w_term0 && r_err;
      end
      RX_FLUSH: begin
        w_push_req  = 1'b1;
        w_push_eop  = 1'b1;
        w_push_err  = r_err;
        w_push_keep = r_hold_keep;
      end
      default: ;
    endcase
  end

  // The last FIFO slot is kept for the truncation marker of an overflowing frame.
  assign w_ovf      = w_push_req && (w_occ >= OCC_LAST);
  assign w_wr_en    = w_ovf ? (r_written && !w_full) : w_push_req;
  assign w_wr_data  = w_ovf ? {1'b1, 1'b1, 1'b0, {LANES{1'b0}}, {DATA_WIDTH{1'b0}}}
                            : {w_push_err, w_push_eop, !r_written, w_push_keep, r_hold_data};
  assign w_good_eop = w_wr_en && w_wr_data[EW-2] && !w_wr_data[EW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RX_IDLE;
      r_hold_data  <= '0;
      r_hold_keep  <= '0;
      r_hold_valid <= 1'b0;
      r_written    <= 1'b0;
      r_err        <= 1'b0;
      r_pkt_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_wr_en) r_written <= 1'b1;
      if (w_good_eop) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      case (r_state)
        RX_IDLE: begin
          if (w_start) begin
            r_state      <= RX_DATA;
            r_hold_valid <= 1'b0;
            r_written    <= 1'b0;
            r_err        <= 1'b0;
          end
        end
        RX_DATA: begin
          if (!w_start) begin
            if (w_ovf) begin
              r_ovf        <= 1'b1;
              r_drop_cnt   <= r_drop_cnt + 1'b1;
              r_hold_valid <= 1'b0;
              // A terminate in the overflowing word already ends the frame.
              r_state      <= w_term_found ? RX_IDLE : RX_DROP;
            end else if (!w_term_found) begin
              r_hold_data  <= xgmii_rxd;
              r_hold_keep  <= '1;
              r_hold_valid <= 1'b1;
              r_err        <= r_err | w_word_err;
            end else if (w_term0) begin
              if (!r_hold_valid) r_drop_cnt <= r_drop_cnt + 1'b1;
              r_hold_valid <= 1'b0;
              r_state      <= RX_IDLE;
            end else begin
              r_hold_data  <= w_part_data;
              r_hold_keep  <= w_part_keep;
              r_hold_valid <= 1'b1;
              r_err        <= r_err | w_word_err;
              r_state      <= RX_FLUSH;
            end
          end
        end
        RX_FLUSH: begin
          r_hold_valid <= 1'b0;
          r_state      <= RX_IDLE;
          if (w_ovf) begin
            r_ovf      <= 1'b1;
            r_drop_cnt <= r_drop_cnt + 1'b1;
          end
        end
        RX_DROP: begin
          if (w_term_found) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (w_wr_en),
    .wr_data   (w_wr_data),
    .rd_en     (w_pop),
    .rd_data   (w_rd_data),
    .occupancy (w_occ),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign rx_valid = !w_empty;
  assign w_pop    = rx_valid && rx_ready;
  assign {rx_err, rx_eop, rx_sop, rx_keep, rx_data} = w_rd_data;

  assign rx_packet_count = r_pkt_cnt;
  assign rx_drop_count   = r_drop_cnt;
  assign rx_overflow     = r_ovf;

endmodule
